eth_tx_crc_mc: RTL and testbench

ETH_TX_CRC_MC -- requirements
Module: eth_tx_crc_mc

---
 rtl/eth_tx_crc_mc.sv | 125 ++++++++++++
 tb/tb_eth_tx_crc_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_crc_mc.sv
// Multi-channel Ethernet TX CRC-32 engine.
// Each channel folds 64-bit beats into a CRC and queues finished frame CRCs in a FWFT FIFO.
module eth_tx_crc_mc #(
  parameter int NCH = 3,
  parameter int AW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*64-1:0]    in_data,
  input  logic [NCH*8-1:0]     in_bvalid,
  input  logic [NCH-1:0]       in_sop,
  input  logic [NCH-1:0]       in_eop,
  input  logic [NCH-1:0]       crc_pull,
  output logic [NCH*32-1:0]    crc_dout,
  output logic [NCH-1:0]       crc_empty,
  output logic [NCH-1:0]       crc_full,
  output logic [NCH*(AW+1)-1:0] crc_count,
  output logic [NCH-1:0]       ovf_err,
  output logic [NCH-1:0]       seq_err,
  input  logic [NCH-1:0]       err_clr
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);

  // Reflected CRC-32, valid bytes folded from byte 0 upward.
  function automatic logic [31:0] crc_fold(
    input logic [31:0] c_in,
    input logic [63:0] d,
    input logic [7:0]  bv
  );
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      if (bv[b]) begin
        c = c ^ {24'h0, d[8*b +: 8]};
        for (int k = 0; k < 8; k++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t      state, state_n;
    logic [31:0] crc_q, crc_nxt;
    logic [31:0] mem [2**AW];
    logic [AW:0] wptr, rptr, count;
    logic        v, s, e;
    logic        accept, seq_set;
    logic        empty, full;
    logic        push, pull, wr, ovf_set;
    logic        ovf_q, seq_q;

    assign v = in_valid[g];
    assign s = in_sop[g];
    assign e = in_eop[g];

    always_comb begin
      state_n = state;
      accept  = 1'b0;
      seq_set = 1'b0;
      if (v) begin
        case (state)
          IDLE: begin
            accept  = s;
            seq_set = !s;
            if (s && !e) state_n = FRAME;
          end
          FRAME: begin
            accept  = 1'b1;
            seq_set = s;
            if (e) state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end

    assign crc_nxt = crc_fold(s ? 32'hFFFFFFFF : crc_q,
                              in_data[64*g +: 64],
                              in_bvalid[8*g +: 8]);

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push    = accept & e;
    assign pull    = crc_pull[g] & !empty;
    // When full, a same-cycle pull frees the slot being written.
    assign wr      = push & (!full | pull);
    assign ovf_set = push & full & !pull;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        crc_q <= 32'hFFFFFFFF;
        wptr  <= '0;
        rptr  <= '0;
        ovf_q <= 1'b0;
        seq_q <= 1'b0;
      end else begin
        state <= state_n;
        if (accept) crc_q <= crc_nxt;
        if (wr)     wptr  <= wptr + 1'b1;
        if (pull)   rptr  <= rptr + 1'b1;
        ovf_q <= ovf_set | (ovf_q & !err_clr[g]);
        seq_q <= seq_set | (seq_q & !err_clr[g]);
      end
    end

    always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= ~crc_nxt;
    end

    assign crc_dout[32*g +: 32]         = mem[rptr[AW-1:0]];
    assign crc_empty[g]                 = empty;
    assign crc_full[g]                  = full;
    assign crc_count[(AW+1)*g +: AW+1]  = count;
    assign ovf_err[g]                   = ovf_q;
    assign seq_err[g]                   = seq_q;
  end

endmodule

// File: tb/tb_eth_tx_crc_mc.sv
// Scoreboard bench for eth_tx_crc_mc: stimulus queues expected CRCs,
// a negedge monitor checks every pop against the queue head.
module tb_eth_tx_crc_mc;
  localparam int NCH = 3;
  localparam int AW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        in_valid, in_sop, in_eop, crc_pull, err_clr;
  logic [NCH*64-1:0]     in_data;
  logic [NCH*8-1:0]      in_bvalid;
  logic [NCH*32-1:0]     crc_dout;
  logic [NCH-1:0]        crc_empty, crc_full, ovf_err, seq_err;
  logic [NCH*(AW+1)-1:0] crc_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq [NCH][$];

  eth_tx_crc_mc #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_bvalid(in_bvalid),
    .in_sop(in_sop), .in_eop(in_eop), .crc_pull(crc_pull),
    .crc_dout(crc_dout), .crc_empty(crc_empty), .crc_full(crc_full),
    .crc_count(crc_count), .ovf_err(ovf_err), .seq_err(seq_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC over the valid bytes of one beat.
  function automatic logic [31:0] ref_beat(input logic [31:0] c,
                                           input logic [63:0] d,
                                           input logic [7:0]  bv);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 64; i++) begin
      if (bv[i/8]) begin
        fb = r[0] ^ d[i];
        r  = {1'b0, r[31:1]};
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return r;
  endfunction

  function automatic logic [AW:0] cnt(input int c);
    return crc_count[(AW+1)*c +: AW+1];
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [63:0] d,
                          input logic [7:0] bv, input logic s, input logic e);
    in_valid[ch]         = 1'b1;
    in_data[64*ch +: 64] = d;
    in_bvalid[8*ch +: 8] = bv;
    in_sop[ch]           = s;
    in_eop[ch]           = e;
  endtask

  task automatic clr_beats();
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
  endtask

  task automatic send(input int ch, input logic [63:0] d,
                      input logic [7:0] bv, input logic s, input logic e);
    set_beat(ch, d, bv, s, e);
    tick();
    clr_beats();
  endtask

  task automatic pull(input int ch);
    crc_pull[ch] = 1'b1;
    tick();
    crc_pull[ch] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (crc_pull[c] && !crc_empty[c]) begin
        if (sbq[c].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_ch%0d got=%h exp=none", c, crc_dout[32*c +: 32]);
        end else begin
          chk($sformatf("pop_ch%0d", c), crc_dout[32*c +: 32],
              sbq[c].pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    logic [7:0]  bv;
    logic [31:0] e;

    rst = 1'b1;
    in_data = '0; in_bvalid = '0; crc_pull = '0; err_clr = '0;
    clr_beats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", 32'(crc_empty), 32'h7);
    chk("rst_full",  32'(crc_full),  32'h0);
    chk("rst_count", 32'(crc_count), 32'h0);
    chk("rst_ovf",   32'(ovf_err),   32'h0);
    chk("rst_seq",   32'(seq_err),   32'h0);

    // "123456789" over two beats
    send(0, 64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
    chk("ch0_empty_mid", 32'(crc_empty[0]), 32'h1);
    sbq[0].push_back(32'hCBF43926);
    send(0, 64'h39, 8'h01, 1'b0, 1'b1);
    chk("ch0_empty_after_eop", 32'(crc_empty[0]), 32'h0);
    chk("ch0_dout_check", crc_dout[31:0], 32'hCBF43926);
    pull(0);
    chk("ch0_empty_after_pop", 32'(crc_empty[0]), 32'h1);

    // "12345678" single beat
    sbq[0].push_back(32'h9AE0DAAF);
    send(0, 64'h3837363534333231, 8'hFF, 1'b1, 1'b1);
    chk("single_dout", crc_dout[31:0], 32'h9AE0DAAF);
    chk("others_empty", 32'(crc_empty[2:1]), 32'h3);
    pull(0);

    // fill ch1 beyond capacity
    for (int i = 0; i < 17; i++) begin
      d  = 64'h3837363534333231 + 64'(i) * 64'h0101;
      bv = (i % 3 == 0) ? 8'h0F : 8'hFF;
      if (i < 16) sbq[1].push_back(~ref_beat(32'hFFFFFFFF, d, bv));
      if (i == 16) begin
        chk("full_after16", 32'(crc_full[1]), 32'h1);
        chk("count16", 32'(cnt(1)), 32'd16);
        chk("no_ovf_yet", 32'(ovf_err[1]), 32'h0);
      end
      send(1, d, bv, 1'b1, 1'b1);
    end
    chk("ovf_set", 32'(ovf_err[1]), 32'h1);
    chk("count_still16", 32'(cnt(1)), 32'd16);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("ovf_cleared", 32'(ovf_err[1]), 32'h0);

    // push and pull together while full
    d = 64'hDEADBEEF_01234567;
    sbq[1].push_back(~ref_beat(32'hFFFFFFFF, d, 8'hFF));
    set_beat(1, d, 8'hFF, 1'b1, 1'b1);
    crc_pull[1] = 1'b1;
    tick();
    clr_beats();
    crc_pull[1] = 1'b0;
    chk("full_pp_count", 32'(cnt(1)), 32'd16);
    chk("full_pp_ovf", 32'(ovf_err[1]), 32'h0);
    for (int i = 0; i < 16; i++) pull(1);
    chk("ch1_drained", 32'(crc_empty[1]), 32'h1);
    pull(1);
    chk("pull_empty_count", 32'(cnt(1)), 32'd0);

    // three-beat frame, partial last beat
    e = ref_beat(32'hFFFFFFFF, 64'h1122334455667788, 8'hFF);
    e = ref_beat(e, 64'h99AABBCCDDEEFF00, 8'hFF);
    e = ref_beat(e, 64'h0000000000ABCDEF, 8'h07);
    sbq[1].push_back(~e);
    send(1, 64'h1122334455667788, 8'hFF, 1'b1, 1'b0);
    send(1, 64'h99AABBCCDDEEFF00, 8'hFF, 1'b0, 1'b0);
    send(1, 64'h0000000000ABCDEF, 8'h07, 1'b0, 1'b1);
    pull(1);

    // sop inside an open frame on ch2
    send(2, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b1, 1'b0);
    send(2, 64'h5555555555555555, 8'hFF, 1'b1, 1'b0);
    chk("seq_restart", 32'(seq_err[2]), 32'h1);
    e = ref_beat(32'hFFFFFFFF, 64'h5555555555555555, 8'hFF);
    e = ref_beat(e, 64'h0000000000001234, 8'h03);
    sbq[2].push_back(~e);
    send(2, 64'h0000000000001234, 8'h03, 1'b0, 1'b1);
    chk("restart_count", 32'(cnt(2)), 32'd1);
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    chk("seq_cleared", 32'(seq_err[2]), 32'h0);
    pull(2);
    err_clr[2] = 1'b1;
    send(2, 64'h77, 8'h01, 1'b0, 1'b1);
    err_clr[2] = 1'b0;
    chk("seq_set_wins", 32'(seq_err[2]), 32'h1);
    chk("stray_no_push", 32'(cnt(2)), 32'd0);
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;

    // eop on every channel in one cycle
    for (int c = 0; c < NCH; c++) begin
      d = 64'h0F0E0D0C0B0A0908 ^ 64'(c);
      sbq[c].push_back(~ref_beat(32'hFFFFFFFF, d, 8'hFF));
      set_beat(c, d, 8'hFF, 1'b1, 1'b1);
    end
    tick();
    clr_beats();
    for (int c = 0; c < NCH; c++)
      chk($sformatf("all_count_ch%0d", c), 32'(cnt(c)), 32'd1);
    crc_pull = '1;
    tick();
    crc_pull = '0;
    chk("all_empty", 32'(crc_empty), 32'h7);

    // reset between the two beats of a frame
    send(0, 64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_empty", 32'(crc_empty), 32'h7);
    chk("midrst_count", 32'(crc_count), 32'h0);
    chk("midrst_errs", 32'({ovf_err, seq_err}), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send(0, 64'h39, 8'h01, 1'b0, 1'b1);
    chk("postrst_seq", 32'(seq_err[0]), 32'h1);
    chk("postrst_empty", 32'(crc_empty[0]), 32'h1);

    for (int c = 0; c < NCH; c++)
      chk($sformatf("sb_left_ch%0d", c), 32'(sbq[c].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
